// File: rtl/min3_stream_driver.sv
// Streaming front-end for a three-input minimum comparator: packs byte triples into
// registered operands, waits out the comparator latency, returns d and self-checks it.
module min3_stream_driver #(
    parameter int DW      = 8,
    parameter int CMP_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] cmp_a,
    output logic [DW-1:0] cmp_b,
    output logic [DW-1:0] cmp_c,
    input  logic [DW-1:0] cmp_d,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          err,
    output logic [15:0]   tri_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the payload is held stable while valid waits.

    localparam logic [3:0] LAT = 4'(CMP_LAT);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_WAIT,
        ST_OUTPUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    bidx;
    logic [DW-1:0] sh0;
    logic [DW-1:0] sh1;
    logic [DW-1:0] ref_min;
    logic [3:0]    wcnt;
    logic          s_acc;
    logic          last_byte;
    logic          lat_hit;
    logic          m_acc;

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic [DW-1:0] z);
        logic [DW-1:0] m;
        m = (x < y) ? x : y;
        return (z < m) ? z : m;
    endfunction

    assign s_ready   = (state == ST_COLLECT);
    assign s_acc     = s_valid && s_ready;
    assign last_byte = s_acc && (bidx == 2'd2);
    assign lat_hit   = (state == ST_WAIT) && (wcnt == LAT);
    assign m_acc     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (last_byte) state_nxt = ST_WAIT;
            ST_WAIT:    if (lat_hit)   state_nxt = ST_OUTPUT;
            ST_OUTPUT:  if (m_acc)     state_nxt = ST_COLLECT;
            default:                   state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx    <= 2'd0;
            sh0     <= '0;
            sh1     <= '0;
            cmp_a   <= '0;
            cmp_b   <= '0;
            cmp_c   <= '0;
            ref_min <= '0;
            wcnt    <= 4'd0;
            m_valid <= 1'b0;
            m_data  <= '0;
            err     <= 1'b0;
            tri_cnt <= 16'd0;
        end else begin
            if (s_acc) begin
                case (bidx)
                    2'd0: begin
                        sh0  <= s_data;
                        bidx <= 2'd1;
                    end
                    2'd1: begin
                        sh1  <= s_data;
                        bidx <= 2'd2;
                    end
                    default: begin
                        // All three operands switch on one edge so the comparator never sees a mix.
                        cmp_a   <= sh0;
                        cmp_b   <= sh1;
                        cmp_c   <= s_data;
                        ref_min <= min3(sh0, sh1, s_data);
                        wcnt    <= 4'd0;
                    end
                endcase
            end
            if (state == ST_WAIT) begin
                if (lat_hit) begin
                    m_data  <= cmp_d;
                    m_valid <= 1'b1;
                    err     <= err | (cmp_d != ref_min);
                end else begin
                    wcnt <= wcnt + 4'd1;
                end
            end
            if (m_acc) begin
                m_valid <= 1'b0;
                tri_cnt <= tri_cnt + 16'd1;
                bidx    <= 2'd0;
            end
        end
    end

endmodule
